// File: rtl/aes_out_pkg.sv
// Shared widths, the control-state enum and word selection for the AES output serializer.
// Any module that needs these imports the package with aes_out_pkg::*.
package aes_out_pkg;
  localparam int BLK_W         = 128;
  localparam int WORD_W        = 32;
  localparam int WORDS_PER_BLK = 4;

  typedef enum logic {EMPTY, STREAM} state_e;

  // Word 0 is the most-significant quarter of the block.
  function automatic logic [WORD_W-1:0] blk_word(input logic [BLK_W-1:0] blk,
                                                 input logic [1:0]       idx);
    logic [WORD_W-1:0] w;
    case (idx)
      2'd0:    w = blk[127:96];
      2'd1:    w = blk[95:64];
      2'd2:    w = blk[63:32];
      default: w = blk[31:0];
    endcase
    return w;
  endfunction
endpackage

// File: rtl/aes_blk_fifo.sv
// Circular buffer of DEPTH 128-bit blocks with a combinational head read.
// The caller gates push and pop, so a push into a full buffer only happens alongside a pop.
module aes_blk_fifo
  import aes_out_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [BLK_W-1:0]         wdata,
  output logic [BLK_W-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [BLK_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
endmodule

// File: rtl/aes_out_serializer.sv
// Buffers 128-bit AES blocks and emits them as 32-bit words, MSW first, on a valid/ready port.
// Define AES_OUT_STAT_EN to add the saturating 16-bit drop_cnt output.
module aes_out_serializer
  import aes_out_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BLK_W-1:0]  C,
  input  logic              valid,
  output logic [WORD_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              full,
  output logic              overflow
`ifdef AES_OUT_STAT_EN
  ,
  output logic [15:0]       drop_cnt
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;

  state_e           state_q;
  logic [1:0]       widx_q;
  logic             overflow_q;
  logic [BLK_W-1:0] head_blk;
  logic [CW-1:0]    count;
  logic             pop_word, final_pop, push, drop;

  assign full       = (count == CW'(DEPTH));
  assign dout_valid = (state_q == STREAM);
  assign dout       = dout_valid ? blk_word(head_blk, widx_q) : '0;
  assign overflow   = overflow_q;

  // A full buffer still accepts a block on the edge its head block leaves.
  assign pop_word  = dout_valid && dout_ready;
  assign final_pop = pop_word && (widx_q == 2'(WORDS_PER_BLK - 1));
  assign push      = valid && (!full || final_pop);
  assign drop      = valid && full && !final_pop;

  aes_blk_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (final_pop),
    .wdata (C),
    .rdata (head_blk),
    .count (count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      widx_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (pop_word) widx_q <= widx_q + 2'd1;
      if (drop)     overflow_q <= 1'b1;
      case (state_q)
        EMPTY:   if (push) state_q <= STREAM;
        STREAM:  if (final_pop && count == CW'(1) && !push) state_q <= EMPTY;
        default: state_q <= EMPTY;
      endcase
    end
  end

`ifdef AES_OUT_STAT_EN
  logic [15:0] drop_cnt_q;

  always_ff @(posedge clk) begin
    if (rst)                              drop_cnt_q <= '0;
    else if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
  end

  assign drop_cnt = drop_cnt_q;
`endif
endmodule

// File: tb/tb_aes_out_serializer.sv
// Self-checking bench for aes_out_serializer: directed scenarios plus randomized traffic
// compared against a block-queue reference model.
module tb_aes_out_serializer;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] C = '0;
  logic         valid = 1'b0;
  logic [31:0]  dout;
  logic         dout_valid;
  logic         dout_ready = 1'b0;
  logic         full;
  logic         overflow;
`ifdef AES_OUT_STAT_EN
  logic [15:0]  drop_cnt;
`endif

  int n_run = 0;
  int n_fail = 0;

  // Reference model: queue of buffered blocks plus index of the next word of the head.
  logic [127:0] mq[$];
  int           mw = 0;
  bit           movf = 0;
  int           mdrops = 0;

  localparam logic [127:0] KBLK = 128'h3925841d02dc09fbdc118597196a0b32;

  always #5 clk = ~clk;

  aes_out_serializer #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .C          (C),
    .valid      (valid),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .full       (full),
    .overflow   (overflow)
`ifdef AES_OUT_STAT_EN
    ,
    .drop_cnt   (drop_cnt)
`endif
  );

  function automatic logic [31:0] word_of(input logic [127:0] b, input int k);
    return b[127-32*k -: 32];
  endfunction

  function automatic logic [31:0] m_dout();
    if (mq.size() == 0) return 32'h0;
    return word_of(mq[0], mw);
  endfunction

  task automatic model_edge(input bit v, input logic [127:0] c, input bit r);
    bit xfer, fin, room;
    xfer = (mq.size() != 0) && r;
    fin  = xfer && (mw == 3);
    room = (mq.size() < DEPTH) || fin;
    if (xfer) begin
      mw = (mw + 1) % 4;
      if (fin) void'(mq.pop_front());
    end
    if (v) begin
      if (room) mq.push_back(c);
      else begin
        movf = 1;
        if (mdrops < 65535) mdrops++;
      end
    end
  endtask

  task automatic step(input bit v, input logic [127:0] c, input bit r);
    valid = v; C = c; dout_ready = r;
    @(posedge clk);
    model_edge(v, c, r);
    #1;
  endtask

  task automatic do_reset(input bit v, input bit r);
    rst = 1'b1; valid = v; dout_ready = r; C = {4{$urandom}};
    @(posedge clk);
    mq.delete(); mw = 0; movf = 0; mdrops = 0;
    #1;
    rst = 1'b0; valid = 1'b0; dout_ready = 1'b0;
  endtask

  function automatic logic [127:0] rand_blk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic test_reset();
    do_reset(1'b1, 1'b1);
    rst = 1'b1;
    do_reset(1'b1, 1'b1);
    n_run++; if (dout !== 32'h0) begin n_fail++; $display("FAIL reset_dout got=%h exp=0", dout); end
    n_run++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dout_valid got=%b exp=0", dout_valid); end
    n_run++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got=%b exp=0", full); end
    n_run++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
`ifdef AES_OUT_STAT_EN
    n_run++; if (drop_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_drop_cnt got=%0d exp=0", drop_cnt); end
`endif
  endtask

  task automatic test_single_block();
    logic [31:0] exp_w [4];
    exp_w = '{32'h3925841d, 32'h02dc09fb, 32'hdc118597, 32'h196a0b32};
    do_reset(1'b0, 1'b0);
    step(1'b1, KBLK, 1'b1);
    for (int k = 0; k < 4; k++) begin
      n_run++;
      if (dout !== exp_w[k] || dout_valid !== 1'b1) begin
        n_fail++; $display("FAIL single_word%0d got=%h/%b exp=%h/1", k, dout, dout_valid, exp_w[k]);
      end
      step(1'b0, '0, 1'b1);
    end
    n_run++;
    if (dout_valid !== 1'b0 || dout !== 32'h0) begin
      n_fail++; $display("FAIL single_empty got=%h/%b exp=0/0", dout, dout_valid);
    end
  endtask

  task automatic test_backpressure();
    do_reset(1'b0, 1'b0);
    step(1'b1, KBLK, 1'b0);
    for (int i = 0; i < 5; i++) begin
      n_run++;
      if (dout !== 32'h3925841d || dout_valid !== 1'b1) begin
        n_fail++; $display("FAIL bp_hold%0d got=%h/%b exp=3925841d/1", i, dout, dout_valid);
      end
      step(1'b0, '0, 1'b0);
    end
    for (int k = 0; k < 4; k++) begin
      n_run++;
      if (dout !== word_of(KBLK, k)) begin
        n_fail++; $display("FAIL bp_release%0d got=%h exp=%h", k, dout, word_of(KBLK, k));
      end
      step(1'b0, '0, 1'b1);
    end
  endtask

  task automatic test_overflow();
    logic [127:0] sent [6];
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      sent[i] = rand_blk();
      step(1'b1, sent[i], 1'b0);
      if (i == 3) begin
        n_run++;
        if (full !== 1'b1 || overflow !== 1'b0) begin
          n_fail++; $display("FAIL ovf_full4 got full=%b ovf=%b exp 1/0", full, overflow);
        end
      end
    end
    n_run++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
`ifdef AES_OUT_STAT_EN
    n_run++; if (drop_cnt !== 16'd2) begin n_fail++; $display("FAIL ovf_drop_cnt got=%0d exp=2", drop_cnt); end
`endif
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++) begin
        n_run++;
        if (dout !== word_of(sent[i], k) || dout_valid !== 1'b1) begin
          n_fail++; $display("FAIL ovf_read b%0d w%0d got=%h exp=%h", i, k, dout, word_of(sent[i], k));
        end
        step(1'b0, '0, 1'b1);
      end
    n_run++;
    if (dout_valid !== 1'b0 || overflow !== 1'b1) begin
      n_fail++; $display("FAIL ovf_after got valid=%b ovf=%b exp 0/1", dout_valid, overflow);
    end
  endtask

  task automatic test_simultaneous();
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, rand_blk(), 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
    step(1'b1, rand_blk(), 1'b1);
    n_run++;
    if (full !== 1'b1 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL simul got full=%b ovf=%b exp 1/0", full, overflow);
    end
    for (int i = 0; i < 17; i++) begin
      n_run++;
      if (dout !== m_dout() || dout_valid !== (mq.size() != 0)) begin
        n_fail++; $display("FAIL simul_drain%0d got=%h/%b exp=%h/%b", i, dout, dout_valid, m_dout(), mq.size() != 0);
      end
      step(1'b0, '0, 1'b1);
    end
    n_run++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL simul_empty got=%b exp=0", dout_valid); end
  endtask

  task automatic test_reset_mid();
    logic [127:0] nb;
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, rand_blk(), 1'b0);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    do_reset(1'b0, 1'b1);
    n_run++;
    if (dout_valid !== 1'b0 || full !== 1'b0 || overflow !== 1'b0 || dout !== 32'h0) begin
      n_fail++; $display("FAIL rstmid got valid=%b full=%b ovf=%b dout=%h exp 0/0/0/0", dout_valid, full, overflow, dout);
    end
    nb = rand_blk();
    step(1'b1, nb, 1'b0);
    for (int k = 0; k < 4; k++) begin
      n_run++;
      if (dout !== word_of(nb, k)) begin
        n_fail++; $display("FAIL rstmid_w%0d got=%h exp=%h", k, dout, word_of(nb, k));
      end
      step(1'b0, '0, 1'b1);
    end
  endtask

  task automatic test_stream(input int n_cyc, input bit rnd);
    bit v, r;
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < n_cyc + 24; i++) begin
      v = (i < n_cyc) && (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
      r = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (i >= n_cyc) r = 1'b1;
      step(v, rand_blk(), r);
      n_run++;
      if (dout !== m_dout() || dout_valid !== (mq.size() != 0) ||
          full !== (mq.size() == DEPTH) || overflow !== movf) begin
        n_fail++;
        $display("FAIL stream cyc%0d got dout=%h v=%b full=%b ovf=%b exp dout=%h v=%b full=%b ovf=%b",
                 i, dout, dout_valid, full, overflow, m_dout(), mq.size() != 0, mq.size() == DEPTH, movf);
      end
`ifdef AES_OUT_STAT_EN
      n_run++;
      if (drop_cnt !== 16'(mdrops)) begin
        n_fail++; $display("FAIL stream_drop_cnt cyc%0d got=%0d exp=%0d", i, drop_cnt, mdrops);
      end
`endif
    end
    n_run++;
    if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL stream_drained got=%b exp=0", dout_valid); end
    if (!rnd) begin
      n_run++;
      if (overflow !== 1'b1) begin n_fail++; $display("FAIL stream_overflow got=%b exp=1", overflow); end
    end
  endtask

  initial begin
    test_reset();
    test_single_block();
    test_backpressure();
    test_overflow();
    test_simultaneous();
    test_reset_mid();
    test_stream(100, 1'b0);
    test_stream(400, 1'b1);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/aes_out_serializer.md
AES_OUT_SERIALIZER -- requirements
Module: aes_out_serializer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of 128-bit blocks buffered (power of two, minimum 2).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port C, input, 128 bits: the ciphertext block from the AES core.
REQ-005 The block SHALL have port valid, input, 1 bit: C is a valid block this cycle.
REQ-006 The block SHALL have port dout, output, 32 bits: the current output word.
REQ-007 The block SHALL have port dout_valid, output, 1 bit: dout holds a valid word.
REQ-008 The block SHALL have port dout_ready, input, 1 bit: the consumer accepts dout this cycle.
REQ-009 The block SHALL have port full, output, 1 bit: the buffer holds DEPTH blocks.
REQ-010 The block SHALL have port overflow, output, 1 bit: sticky flag, set when a valid block was dropped.

Function
REQ-011 Push: on a rising edge with valid=1 and (count<DEPTH, or count==DEPTH with the final word of the head block popping that edge), the block SHALL store C at the tail and increment count (net zero change when push and final-word pop coincide).
REQ-012 Drop: valid=1 with count==DEPTH and no final-word pop on that edge SHALL discard C, leave the buffer unchanged and set overflow=1 until reset.
REQ-013 Word order SHALL be most-significant first: C[127:96], C[95:64], C[63:32], C[31:0].
REQ-014 dout_valid SHALL equal (count!=0); dout SHALL be the head block's word selected by the 2-bit word index, and 32'h0 when empty.
REQ-015 Pop: a word transfers on an edge with dout_valid=1 and dout_ready=1; the word index then increments, and on the transfer of word 3 it wraps to 0, the head block is freed and count decrements.
REQ-016 Latency: a block pushed at edge N SHALL present word 0 on dout from edge N onward when the buffer was empty.
REQ-017 dout and dout_valid SHALL hold stable while dout_ready=0.
REQ-018 Control state machine states: EMPTY (count==0) and STREAM (count>0); EMPTY->STREAM on push; STREAM->EMPTY on a final-word pop with count==1 and no push; otherwise it holds.
REQ-019 Pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH; count SHALL be log2(DEPTH)+1 bits.
REQ-020 full SHALL equal (count==DEPTH), driven combinationally from count.
REQ-021 Sustained throughput SHALL be one word per cycle when dout_ready is held at 1.

Reset
REQ-022 On any edge with rst=1, the block SHALL clear count, pointers, word index and overflow, and enter EMPTY, overriding a concurrent push or pop.
REQ-023 While and after reset, dout=0, dout_valid=0, full=0 and overflow=0; storage contents are not reset.
REQ-024 A reset mid-block SHALL discard all buffered and partially sent blocks.

Configuration
REQ-025 With AES_OUT_STAT_EN defined, the block SHALL add output drop_cnt, 16 bits, incremented on each drop, saturating at 16'hFFFF and cleared by reset.
REQ-026 Without AES_OUT_STAT_EN, the drop_cnt port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-027 Shared package aes_out_pkg SHALL hold BLK_W=128, WORD_W=32, WORDS_PER_BLK=4 and the state enum {EMPTY, STREAM}.
REQ-028 Block storage and pointers SHALL be a sub-module aes_blk_fifo (push/pop/count interface), instantiated once.

Verification
REQ-029 Single block: push C=128'h3925841d02dc09fbdc118597196a0b32 with dout_ready=1 -> dout 3925841d, 02dc09fb, dc118597, 196a0b32 on four consecutive cycles, then dout_valid=0.
REQ-030 Backpressure: dout_ready=0 for 5 cycles after a push -> dout stays 3925841d with dout_valid=1; on release, words follow in order.
REQ-031 Overflow: DEPTH=4, dout_ready=0, valid held 1 for 6 cycles -> full=1 after 4 pushes, overflow=1, drop_cnt=2 (macro on), and the first 4 blocks are read back intact.
REQ-032 Simultaneous: with full=1, push coincides with the word-3 pop -> push accepted, full remains 1, overflow stays 0.
REQ-033 Reset mid-block: rst=1 after word 1 of 3 buffered blocks -> next cycle dout_valid=0, count=0, overflow=0; a new push then streams from word 0.
REQ-034 Streaming: the AES core outputs 100 blocks back-to-back with dout_ready=1 and DEPTH=4 -> overflow=1; every accepted block is emitted intact and in order.
